fetch_unit: RTL and testbench

Instruction fetch stage of the multi-cycle RV32 core; sits directly upstream of the decoder.
- Owns the architectural PC.
- Issues one read at a time to instruction memory over an AXI4-Lite-style read channel.
- Presents {instruction, PC} to decode through a valid/ready handshake.
- Accepts jump redirects from the execute/write stage and discards any stale in-flight response.

---
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage, one outstanding AXI4-Lite-style read, valid/ready to decode.
// Define FETCH_MISALIGN_EN to report misaligned redirect targets instead of silently aligning them.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fault_o,
  output logic              misalign_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);
  localparam logic [1:0] REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [1:0] state;
  logic [ADDR_W-1:0] pc, npc;
  logic [ADDR_W-1:2] base;
  logic discard, idle_next, load;
  assign arvalid = rstn && state == REQ;
  assign rready = state == WAIT;
  assign load = state == WAIT && rvalid && !discard && !redirect_i;
  // returning to REQ with no read outstanding: dropped response or consumed/flushed output
  assign idle_next = (state == WAIT && rvalid && (discard || redirect_i)) ||
                     (state == HOLD && (redirect_i || ready_i));
  assign base = redirect_i ? npc[ADDR_W-1:2] : pc[ADDR_W-1:2];
`ifdef FETCH_MISALIGN_EN
  logic mis, mis_go;
  assign npc = redirect_pc_i;
  assign mis_go = idle_next && ((redirect_i && npc[1:0] != 2'b00) || (mis && !redirect_i));
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc_i[1:0];
  assign npc = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign misalign_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= REQ;
      pc <= RESET_PC;
      araddr <= {RESET_PC[ADDR_W-1:2], 2'b00};
      discard <= 1'b0;
      valid_o <= 1'b0;
      instr_o <= NOP;
      pc_o <= '0;
      fault_o <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      mis <= 1'b0;
      misalign_o <= 1'b0;
`endif
    end else begin
      if (redirect_i) pc <= npc;
      if (idle_next) begin
        state <= REQ;
        araddr <= {base, 2'b00};
        valid_o <= 1'b0;
        discard <= 1'b0;
      end
      // the presented request cannot be withdrawn, so its response is marked stale instead
      if (state == REQ && redirect_i) discard <= 1'b1;
      if (state == REQ && arready) state <= WAIT;
      if (state == WAIT && !rvalid && redirect_i) discard <= 1'b1;
      if (load) begin
        state <= HOLD;
        valid_o <= 1'b1;
        instr_o <= rdata;
        pc_o <= pc;
        fault_o <= rresp != 2'b00;
        pc <= pc + ADDR_W'(4);
      end
`ifdef FETCH_MISALIGN_EN
      if (redirect_i) mis <= npc[1:0] != 2'b00;
      if (load) misalign_o <= 1'b0;
      if (mis_go) begin
        state <= HOLD;
        valid_o <= 1'b1;
        misalign_o <= 1'b1;
        instr_o <= NOP;
        pc_o <= redirect_i ? npc : pc;
        fault_o <= 1'b0;
        pc <= {base, 2'b00} + ADDR_W'(4);
        mis <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a single-outstanding memory model.
module tb_fetch_unit;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] araddr, rdata = '0, instr_o, pc_o, redirect_pc_i = '0;
  logic arvalid, arready = 1'b1, rready, rvalid = 1'b0;
  logic fault_o, misalign_o, valid_o, ready_i = 1'b0, redirect_i = 1'b0;
  logic [1:0] rresp = '0;
  int errors = 0, checks = 0;
  int lat = 0, left = 0, stall = 0;
  bit busy = 0;
  logic [31:0] err_addr = 32'hFFFF_FFF0, last_ar = '0;

  fetch_unit dut (
    .clk(clk), .rstn(rstn), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .instr_o(instr_o), .pc_o(pc_o), .fault_o(fault_o), .misalign_o(misalign_o),
    .valid_o(valid_o), .ready_i(ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + {a[11:0], 20'h0};
  endfunction

  // one clock: handshakes are sampled before the edge, memory reacts 1 time unit after it
  task automatic tick();
    bit ar_fire, r_fire;
    logic [31:0] fa;
    ar_fire = arvalid && arready;
    r_fire = rvalid && rready;
    fa = araddr;
    @(posedge clk);
    #1;
    if (r_fire) rvalid = 1'b0;
    if (busy) begin
      left--;
      if (left == 0) begin rvalid = 1'b1; busy = 0; end
    end
    if (ar_fire) begin
      last_ar = fa;
      rdata = mem_word(fa);
      rresp = (fa == err_addr) ? 2'b10 : 2'b00;
      if (lat == 0) rvalid = 1'b1;
      else begin busy = 1; left = lat; end
    end
    arready = stall == 0;
    if (stall > 0) stall--;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid_o !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h want 00000013", instr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fault_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", misalign_o); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b want 0", rready); end
    #2 rstn = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL first_arvalid: got %b want 1", arvalid); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL first_araddr: got %h want 0", araddr); end
  endtask

  task automatic test_basic();
    int n;
    ready_i = 1'b1;
    wait_valid(n);
    checks++; if (n != 2) begin errors++; $display("FAIL latency: got %0d want 2", n); end
    checks++; if (instr_o !== 32'h0010_0093) begin errors++; $display("FAIL basic_instr: got %h want 00100093", instr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h want 0", pc_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL basic_fault: got %b want 0", fault_o); end
    tick();
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL basic_next_arvalid: got %b want 1", arvalid); end
    checks++; if (araddr !== 32'h4) begin errors++; $display("FAIL basic_next_araddr: got %h want 4", araddr); end
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    ready_i = 1'b0;
    wait_valid(n);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", valid_o); end
    checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL bp_pc: got %h want 4", pc_o); end
    checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL bp_instr: got %h want 00500093", instr_o); end
    ok = 1;
    repeat (5) begin
      tick();
      if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== 32'h0050_0093 || arvalid !== 1'b0) ok = 0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_hold_stable: got unstable outputs or arvalid pc=%h instr=%h arvalid=%b", pc_o, instr_o, arvalid); end
    ready_i = 1'b1;
    tick();
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8) begin errors++; $display("FAIL bp_next_araddr: got %b/%h want 1/00000008", arvalid, araddr); end
  endtask

  task automatic test_fault();
    int n;
    err_addr = 32'h8;
    wait_valid(n);
    checks++; if (valid_o !== 1'b1 || fault_o !== 1'b1) begin errors++; $display("FAIL fault_flag: got valid=%b fault=%b want 1/1", valid_o, fault_o); end
    checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL fault_pc: got %h want 8", pc_o); end
    checks++; if (instr_o !== 32'h0090_0093) begin errors++; $display("FAIL fault_instr: got %h want 00900093", instr_o); end
    tick();
    checks++; if (arvalid !== 1'b1 || araddr !== 32'hC) begin errors++; $display("FAIL fault_next_araddr: got %b/%h want 1/0000000c", arvalid, araddr); end
    err_addr = 32'hFFFF_FFF0;
    wait_valid(n);
    checks++; if (fault_o !== 1'b0 || pc_o !== 32'hC) begin errors++; $display("FAIL fault_clear: got fault=%b pc=%h want 0/0000000c", fault_o, pc_o); end
    tick();
  endtask

  task automatic test_redirect_wait();
    int n;
    bit seen;
    lat = 2;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    seen = 0; n = 0;
    while (arvalid !== 1'b1 && n < 10) begin tick(); n++; if (valid_o === 1'b1) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rw_stale: got valid_o=1 with pc=%h want no output", pc_o); end
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h100) begin errors++; $display("FAIL rw_araddr: got %b/%h want 1/00000100", arvalid, araddr); end
    lat = 0;
    wait_valid(n);
    checks++; if (pc_o !== 32'h100 || instr_o !== 32'h1010_0093) begin errors++; $display("FAIL rw_out: got pc=%h instr=%h want 00000100/10100093", pc_o, instr_o); end
    tick();
  endtask

  task automatic test_redirect_req();
    int n;
    bit ok, seen;
    arready = 1'b0; stall = 2;
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    ok = arvalid === 1'b1 && araddr === 32'h104;
    repeat (2) begin tick(); if (!(arvalid === 1'b1 && araddr === 32'h104)) ok = 0; end
    checks++; if (!ok) begin errors++; $display("FAIL rr_hold_addr: got %b/%h want 1/00000104", arvalid, araddr); end
    seen = 0; n = 0;
    do begin tick(); n++; if (valid_o === 1'b1) seen = 1; end while (arvalid !== 1'b1 && n < 10);
    checks++; if (last_ar !== 32'h104) begin errors++; $display("FAIL rr_issued_addr: got %h want 00000104", last_ar); end
    checks++; if (seen) begin errors++; $display("FAIL rr_stale: got valid_o=1 pc=%h want no output", pc_o); end
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h200) begin errors++; $display("FAIL rr_araddr: got %b/%h want 1/00000200", arvalid, araddr); end
    wait_valid(n);
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h200) begin errors++; $display("FAIL rr_out_pc: got %b/%h want 1/00000200", valid_o, pc_o); end
    tick();
  endtask

  task automatic test_redirect_hold();
    int n;
    ready_i = 1'b0;
    wait_valid(n);
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b want 0", valid_o); end
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h300) begin errors++; $display("FAIL rh_araddr: got %b/%h want 1/00000300", arvalid, araddr); end
    ready_i = 1'b1;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h400;
    tick();
    redirect_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || arvalid !== 1'b1 || araddr !== 32'h400) begin errors++; $display("FAIL rv_same_cycle: got valid=%b arvalid=%b araddr=%h want 0/1/00000400", valid_o, arvalid, araddr); end
  endtask

  task automatic test_back_to_back();
    int k;
    bit ok;
    k = 0; ok = 1;
    repeat (9) begin
      tick();
      if (valid_o === 1'b1) begin
        if (pc_o !== 32'h400 + 32'(4 * k)) ok = 0;
        k++;
      end
    end
    checks++; if (k != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", k); end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_pc_seq: got out-of-order pc %h want 400/404/408", pc_o); end
  endtask

  task automatic test_wrap();
    int n;
    bit seen;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    seen = 0; n = 0;
    do begin tick(); n++; if (valid_o === 1'b1) seen = 1; end while (arvalid !== 1'b1 && n < 10);
    checks++; if (last_ar !== 32'h40C || seen) begin errors++; $display("FAIL wrap_discard: got last_ar=%h seen=%b want 0000040c/0", last_ar, seen); end
    checks++; if (araddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_araddr: got %h want fffffffc", araddr); end
    wait_valid(n);
    checks++; if (pc_o !== 32'hFFFF_FFFC || instr_o !== 32'hFFD0_0093) begin errors++; $display("FAIL wrap_out: got %h/%h want fffffffc/ffd00093", pc_o, instr_o); end
    tick();
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %b/%h want 1/00000000", arvalid, araddr); end
  endtask

  task automatic test_misalign();
    int n;
    ready_i = 1'b0;
    wait_valid(n);
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_EN
    checks++; if (valid_o !== 1'b1 || misalign_o !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL mis_flag: got valid=%b mis=%b arvalid=%b want 1/1/0", valid_o, misalign_o, arvalid); end
    checks++; if (pc_o !== 32'h102 || instr_o !== 32'h13 || fault_o !== 1'b0) begin errors++; $display("FAIL mis_out: got %h/%h/%b want 00000102/00000013/0", pc_o, instr_o, fault_o); end
    ready_i = 1'b1;
    tick();
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h104) begin errors++; $display("FAIL mis_next: got %b/%h want 1/00000104", arvalid, araddr); end
    wait_valid(n);
    checks++; if (misalign_o !== 1'b0 || pc_o !== 32'h104) begin errors++; $display("FAIL mis_clear: got %b/%h want 0/00000104", misalign_o, pc_o); end
`else
    checks++; if (valid_o !== 1'b0 || misalign_o !== 1'b0) begin errors++; $display("FAIL mis_off_flag: got valid=%b mis=%b want 0/0", valid_o, misalign_o); end
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h100) begin errors++; $display("FAIL mis_off_araddr: got %b/%h want 1/00000100", arvalid, araddr); end
    ready_i = 1'b1;
    wait_valid(n);
    checks++; if (pc_o !== 32'h100 || misalign_o !== 1'b0) begin errors++; $display("FAIL mis_off_pc: got %h/%b want 00000100/0", pc_o, misalign_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fault();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_hold();
    test_back_to_back();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000");
    $fatal(1);
  end
endmodule
